// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM stage and its MEM/WB register.
package pipe_pkg;

    localparam int XLEN            = 32;
    localparam int WORD_ALIGN_BITS = 2;
    localparam int REG_ADDR_W      = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0]       data;
        logic [XLEN-1:0]       alu;
        logic [REG_ADDR_W-1:0] rd;
        logic                  memtoreg;
        logic                  regwrite;
    } wb_t;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// MEM/WB pipeline register; a bubble kills the write-back controls.
module mem_wb_reg
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  wb_t  d,
    input  logic bubble,
    output wb_t  q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q          <= d;
            q.memtoreg <= d.memtoreg & ~bubble;
            q.regwrite <= d.regwrite & ~bubble;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ready/ack data-memory port, stall generation,
// timeout abort and misalignment detection feeding the MEM/WB register.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = XLEN,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadMEM,
    input  logic                  MemWriteMEM,
    input  logic                  MemToRegMEM,
    input  logic                  RegWriteMEM,
    input  logic [DATA_W-1:0]     AddressMEM,
    input  logic [DATA_W-1:0]     WriteDataMEM,
    input  logic [REG_ADDR_W-1:0] RegDstMEM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     ReadDataWB,
    output logic [DATA_W-1:0]     ALUResultWB,
    output logic [REG_ADDR_W-1:0] RegDstWB,
    output logic                  MemToRegWB,
    output logic                  RegWriteWB,
    output logic                  misalign_err,
    output logic                  bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t state, next;
    logic [CNT_W-1:0] cnt;

    logic mem_op, aligned, issue, timeout, done;
    logic misalign_d, bus_d, bubble;
    wb_t  wb_d, wb_q;
    wb_t  cap;
    logic cap_load;

    assign mem_op  = MemReadMEM | MemWriteMEM;
    assign aligned = (AddressMEM[WORD_ALIGN_BITS-1:0] == '0);
    assign issue   = (state == IDLE) & mem_op & aligned;
    assign timeout = (state == BUSY) & ~mem_ack
                   & (cnt == CNT_W'(TIMEOUT - 1));
    assign done    = (state == BUSY) & (mem_ack | timeout);

    always_comb begin
        next       = state;
        stall      = 1'b0;
        bubble     = 1'b0;
        misalign_d = 1'b0;
        bus_d      = 1'b0;
        wb_d       = '{data:     '0,
                       alu:      AddressMEM,
                       rd:       RegDstMEM,
                       memtoreg: MemToRegMEM,
                       regwrite: RegWriteMEM};
        unique case (state)
            IDLE: begin
                if (mem_op && !aligned) begin
                    bubble     = 1'b1;
                    misalign_d = 1'b1;
                end else if (mem_op) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    next   = BUSY;
                end
            end
            BUSY: begin
                wb_d = cap;
                if (mem_ack) begin
                    wb_d.data = cap_load ? mem_rdata : '0;
                    next      = IDLE;
                end else if (timeout) begin
                    bubble = 1'b1;
                    bus_d  = 1'b1;
                    next   = IDLE;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cap          <= '0;
            cap_load     <= 1'b0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            state        <= next;
            misalign_err <= misalign_d;
            bus_err      <= bus_d;
            if (issue) begin
                mem_req   <= 1'b1;
                mem_we    <= MemWriteMEM;
                mem_addr  <= {AddressMEM[DATA_W-1:WORD_ALIGN_BITS],
                              {WORD_ALIGN_BITS{1'b0}}};
                mem_wdata <= WriteDataMEM;
                cap       <= wb_d;
                cap_load  <= ~MemWriteMEM;
                cnt       <= '0;
            end else if (done) begin
                mem_req <= 1'b0;
                cnt     <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .d      (wb_d),
        .bubble (bubble),
        .q      (wb_q)
    );

    assign ReadDataWB  = wb_q.data;
    assign ALUResultWB = wb_q.alu;
    assign RegDstWB    = wb_q.rd;
    assign MemToRegWB  = wb_q.memtoreg;
    assign RegWriteWB  = wb_q.regwrite;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus
// hand-written load, store, timeout and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadMEM, MemWriteMEM, MemToRegMEM, RegWriteMEM;
    logic [31:0] AddressMEM, WriteDataMEM;
    logic [4:0]  RegDstMEM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] ReadDataWB, ALUResultWB;
    logic [4:0]  RegDstWB;
    logic        MemToRegWB, RegWriteWB, misalign_err, bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemReadMEM   (MemReadMEM),
        .MemWriteMEM  (MemWriteMEM),
        .MemToRegMEM  (MemToRegMEM),
        .RegWriteMEM  (RegWriteMEM),
        .AddressMEM   (AddressMEM),
        .WriteDataMEM (WriteDataMEM),
        .RegDstMEM    (RegDstMEM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .ReadDataWB   (ReadDataWB),
        .ALUResultWB  (ALUResultWB),
        .RegDstWB     (RegDstWB),
        .MemToRegWB   (MemToRegWB),
        .RegWriteWB   (RegWriteWB),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic m2r,
                         input logic rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        MemReadMEM   = r;
        MemWriteMEM  = w;
        MemToRegMEM  = m2r;
        RegWriteMEM  = rw;
        AddressMEM   = a;
        WriteDataMEM = wd;
        RegDstMEM    = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        r, w, m2r, rw;
        logic [31:0] a;
        logic [4:0]  rd;
        logic [31:0] e_alu;
        logic [4:0]  e_rd;
        logic        e_rw, e_m2r, e_mis;
    } vec_t;

    vec_t vecs[5];
    int   stall_cnt, req_cnt;
    logic seen_drop;

    initial begin
        vecs[0] = '{0, 0, 0, 1, 32'h0000_0010, 5'd5,
                    32'h0000_0010, 5'd5, 1, 0, 0};
        vecs[1] = '{0, 0, 0, 1, 32'hFFFF_FFFF, 5'd31,
                    32'hFFFF_FFFF, 5'd31, 1, 0, 0};
        vecs[2] = '{1, 0, 1, 1, 32'h0000_0102, 5'd7,
                    32'h0000_0102, 5'd7, 0, 0, 1};
        vecs[3] = '{0, 1, 0, 0, 32'h0000_0103, 5'd2,
                    32'h0000_0103, 5'd2, 0, 0, 1};
        vecs[4] = '{0, 0, 1, 0, 32'h0000_0000, 5'd0,
                    32'h0000_0000, 5'd0, 0, 1, 0};

        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        drive(1, 0, 1, 1, 32'h100, 32'h99, 5'd3);
        repeat (2) tick();
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", ReadDataWB, 0);
        chk("rst_alu", ALUResultWB, 0);
        chk("rst_rd", {27'b0, RegDstWB}, 0);
        chk("rst_wb_ctl", {30'b0, MemToRegWB, RegWriteWB}, 0);
        chk("rst_errs", {30'b0, misalign_err, bus_err}, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_stall", {31'b0, stall}, 0);
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].r, vecs[i].w, vecs[i].m2r, vecs[i].rw,
                  vecs[i].a, 32'hA5A5_0000, vecs[i].rd);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'b0, stall}, 0);
            tick();
            chk($sformatf("v%0d_alu", i), ALUResultWB, vecs[i].e_alu);
            chk($sformatf("v%0d_rd", i), {27'b0, RegDstWB},
                {27'b0, vecs[i].e_rd});
            chk($sformatf("v%0d_rw", i), {31'b0, RegWriteWB},
                {31'b0, vecs[i].e_rw});
            chk($sformatf("v%0d_m2r", i), {31'b0, MemToRegWB},
                {31'b0, vecs[i].e_m2r});
            chk($sformatf("v%0d_mis", i), {31'b0, misalign_err},
                {31'b0, vecs[i].e_mis});
            chk($sformatf("v%0d_req", i), {31'b0, mem_req}, 0);
            chk($sformatf("v%0d_data", i), ReadDataWB, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("mis_pulse_clear", {31'b0, misalign_err}, 0);

        // load at 0x100, ack in the fourth cycle after presenting it
        drive(1, 0, 1, 1, 32'h100, 32'h0, 5'd9);
        stall_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (stall) stall_cnt++;
            tick();
            if (c < 3) begin
                chk($sformatf("ld_req%0d", c), {31'b0, mem_req}, 1);
                chk($sformatf("ld_addr%0d", c), mem_addr, 32'h100);
                chk($sformatf("ld_we%0d", c), {31'b0, mem_we}, 0);
                chk($sformatf("ld_bubble%0d", c), {31'b0, RegWriteWB}, 0);
            end
        end
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ld_stall_cycles", stall_cnt, 3);
        chk("ld_data", ReadDataWB, 32'hDEAD_BEEF);
        chk("ld_ctl", {30'b0, MemToRegWB, RegWriteWB}, 3);
        chk("ld_alu", ALUResultWB, 32'h100);
        chk("ld_rd", {27'b0, RegDstWB}, 9);
        chk("ld_req_drop", {31'b0, mem_req}, 0);
        tick();

        // store with immediate ack
        drive(0, 1, 0, 0, 32'h104, 32'h55, 5'd0);
        @(negedge clk);
        chk("st_stall_issue", {31'b0, stall}, 1);
        tick();
        chk("st_req", {31'b0, mem_req}, 1);
        chk("st_we", {31'b0, mem_we}, 1);
        chk("st_wdata", mem_wdata, 32'h55);
        chk("st_addr", mem_addr, 32'h104);
        chk("st_rw0", {31'b0, RegWriteWB}, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("st_stall_ack", {31'b0, stall}, 0);
        tick();
        mem_ack = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("st_req_drop", {31'b0, mem_req}, 0);
        chk("st_rw1", {31'b0, RegWriteWB}, 0);
        chk("st_data", ReadDataWB, 0);
        tick();

        // load that never gets an ack
        drive(1, 0, 1, 1, 32'h200, 32'h0, 5'd4);
        stall_cnt = 0;
        req_cnt   = 0;
        seen_drop = 1'b0;
        for (int c = 0; c < 40 && !seen_drop; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            tick();
            if (mem_req) begin
                req_cnt++;
                chk("to_bubble", {31'b0, RegWriteWB}, 0);
            end else begin
                seen_drop = 1'b1;
            end
        end
        chk("to_dropped", {31'b0, seen_drop}, 1);
        chk("to_req_cycles", req_cnt, 15);
        chk("to_stall_cycles", stall_cnt, 15);
        chk("to_bus_err", {31'b0, bus_err}, 1);
        chk("to_rw", {31'b0, RegWriteWB}, 0);
        chk("to_data", ReadDataWB, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_req", {31'b0, mem_req}, 0);
        chk("late_ack_buserr", {31'b0, bus_err}, 0);
        chk("late_ack_data", ReadDataWB, 0);
        chk("late_ack_rw", {31'b0, RegWriteWB}, 0);

        // reset while BUSY
        drive(1, 0, 1, 1, 32'h300, 32'h0, 5'd6);
        repeat (3) tick();
        chk("rb_req_before", {31'b0, mem_req}, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rb_req_now", {31'b0, mem_req}, 0);
        chk("rb_rw", {31'b0, RegWriteWB}, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rb_stall", {31'b0, stall}, 0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        chk("rb_ack_req", {31'b0, mem_req}, 0);
        chk("rb_ack_data", ReadDataWB, 0);
        chk("rb_ack_rw", {31'b0, RegWriteWB}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage directly downstream of the EX/MEM register.
- Drives a ready/ack data-memory port for loads and stores.
- Stalls the upstream pipeline while a memory access is outstanding.
- Holds the MEM/WB pipeline register that feeds write-back, and flags misaligned and timed-out accesses.

Parameters:
DATA_W, 32, data and address width
TIMEOUT, 15, max BUSY cycles waiting for mem_ack before aborting (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
MemReadMEM  in  1  load request from EX/MEM
MemWriteMEM  in  1  store request from EX/MEM
MemToRegMEM  in  1  write-back select (1 = memory data)
RegWriteMEM  in  1  register write enable
AddressMEM  in  DATA_W  ALU result / memory byte address
WriteDataMEM  in  DATA_W  store data
RegDstMEM  in  5  destination register
mem_req  out  1  memory request, registered
mem_we  out  1  1 = store, registered
mem_addr  out  DATA_W  word-aligned byte address, registered
mem_wdata  out  DATA_W  store data, registered
mem_ack  in  1  memory completion, 1-cycle pulse
mem_rdata  in  DATA_W  load data, valid with mem_ack
stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
ReadDataWB  out  DATA_W  loaded data
ALUResultWB  out  DATA_W  pass-through of AddressMEM
RegDstWB  out  5  destination register
MemToRegWB  out  1  write-back select
RegWriteWB  out  1  write enable to register file
misalign_err  out  1  1-cycle pulse, registered
bus_err  out  1  1-cycle pulse, registered

Behaviour:
- Reset: rst low asynchronously forces all registered outputs to 0 and state to IDLE. This includes mem_req, mem_we, mem_addr, mem_wdata, all *WB outputs, misalign_err, bus_err and the timeout counter.
- Reset mid-BUSY: the request is dropped immediately. A later mem_ack is ignored.
- Operation decode:
  - mem_op = MemReadMEM | MemWriteMEM.
  - If both MemReadMEM and MemWriteMEM are set, the access is a store.
  - aligned = (AddressMEM[1:0] == 0).
- FSM states: IDLE, BUSY.
- IDLE, no mem_op:
  - stall = 0.
  - At the edge, the MEM/WB register latches ALUResult, RegDst, MemToReg and RegWrite.
  - ReadDataWB = 0. Latency is 1 cycle.
- IDLE, mem_op and misaligned:
  - stall = 0; no request is issued.
  - At the edge, MEM/WB latches with RegWriteWB = 0 and MemToRegWB = 0, and misalign_err = 1 for one cycle.
- IDLE, mem_op and aligned:
  - stall = 1.
  - At the edge: state goes to BUSY; mem_req = 1; mem_we = store; mem_addr = AddressMEM; mem_wdata = WriteDataMEM.
  - Control fields are captured internally.
  - MEM/WB receives a bubble: RegWriteWB = 0, MemToRegWB = 0.
- BUSY:
  - stall = !mem_ack.
  - mem_req is held with address and data stable.
  - The counter increments each cycle without ack.
- BUSY, mem_ack = 1:
  - At the edge: mem_req goes to 0; state goes to IDLE.
  - MEM/WB loads the captured fields, with ReadDataWB = mem_rdata for a load and 0 for a store.
  - The counter is cleared.
  - Minimum load latency is 2 cycles: issue cycle plus ack cycle.
- BUSY, counter reaches TIMEOUT-1 without ack:
  - stall = 0 in that cycle.
  - At the edge: mem_req goes to 0; state goes to IDLE.
  - MEM/WB loads with RegWriteWB = 0 and ReadDataWB = 0; bus_err = 1 for one cycle.
- mem_ack while IDLE is ignored.
- Back-to-back memory ops: the next op is decoded in the cycle after completion. There is no overlap; at most one outstanding access.
- Error pulses clear on the next edge.
- stall must depend only on state, mem_op, aligned, mem_ack and counter. It must never depend on stall itself.

Decomposition:
- Shared package pipe_pkg: state enum {IDLE, BUSY}; WB bundle struct {data, alu, rd, memtoreg, regwrite}; constants WORD_ALIGN_BITS = 2 and REG_ADDR_W = 5.
- Sub-module mem_wb_reg: plain MEM/WB register with async active-low reset and a bubble input. It is instantiated once.
- FSM, counter and memory-port registers live in mem_stage.

Test Plan:
- Reset: rst = 0 with mem_op present and mem_ack = 1 -> all outputs 0, stall = 0 for the IDLE/no-op case, no mem_req.
- ALU op passthrough (RegWriteMEM = 1, AddressMEM = 0x0000_0010, RegDstMEM = 5) -> next cycle ALUResultWB = 0x10, RegDstWB = 5, RegWriteWB = 1, stall never 1.
- Load at 0x100 with mem_ack 3 cycles after issue and mem_rdata = 0xDEADBEEF -> stall = 1 for 3 cycles (issue plus 2 waits), mem_req = 1 with mem_addr = 0x100. One cycle after ack: ReadDataWB = 0xDEADBEEF, MemToRegWB = 1, RegWriteWB = 1; bubbles precede it.
- Store at 0x104 with WriteDataMEM = 0x55 and immediate ack -> mem_we = 1, mem_wdata = 0x55, stall for 1 cycle, RegWriteWB = 0 throughout.
- Misaligned load at 0x102 -> no mem_req, stall = 0, misalign_err pulse, RegWriteWB = 0.
- Load with mem_ack never asserted and TIMEOUT = 15 -> mem_req high for exactly 15 cycles, then bus_err pulse and RegWriteWB = 0. A late mem_ack after that is ignored. Repeat with rst = 0 asserted mid-BUSY -> mem_req = 0 immediately.
